sqrt_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one piecewise square-root pipeline (Q5.11, 16-bit, fixed latency, no stall) between NUM_REQ requesters. It accepts at most one operand per cycle via valid/ready and issues it to the datapath. It carries a requester tag alongside each operand through a shadow tag pipeline, so every result is returned to its originator on a shared response bus with a one-hot valid. It sits between the feature-extraction front ends and the single sqrt datapath instance.

---
 rtl/sqrt_rr_scheduler_if.sv | 24 ++
 rtl/sqrt_rr_scheduler.sv | 130 +++++++++++++
 tb/tb_sqrt_rr_scheduler.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_rr_scheduler_if.sv
// Requester-side handshake and shared response bus of the sqrt round-robin scheduler.
interface sqrt_rr_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned BITSIZE = 16
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*BITSIZE-1:0] req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [BITSIZE-1:0]         rsp_data;
    logic                       rsp_neg;

    // Requesters drive operands and sink results.
    modport master (
        output req_valid, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_neg
    );

    // Scheduler grants operands and returns results.
    modport slave (
        input  req_valid, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_neg
    );
endinterface

// File: rtl/sqrt_rr_scheduler.sv
// Round-robin arbiter sharing one fixed-latency sqrt pipeline among NUM_REQ requesters.
// A shadow tag pipeline carries {valid, requester id, negative} alongside each operand
// so results are routed back on a shared bus with a one-hot strobe.
module sqrt_rr_scheduler #(
    parameter int unsigned BITSIZE  = 16,
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned CNT_W    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    sqrt_rr_scheduler_if.slave   bus,
    output logic [BITSIZE-1:0]   sq_data_in,
    input  logic [BITSIZE-1:0]   sq_data_out,
    output logic [CNT_W-1:0]     inflight,
    output logic                 idle
);

    typedef struct packed {
        logic            v;
        logic [ID_W-1:0] id;
        logic            neg;
    } tag_t;

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    idx_c;
    logic [ID_W-1:0]    gnt_id_c;
    logic               gnt_any_c;
    logic [BITSIZE-1:0] gnt_data_c;
    logic               gnt_neg_c;

    // Tag stage k describes the operand that entered the datapath k edges ago;
    // the last stage lines up with sq_data_out.
    tag_t               tag_q [PIPE_LAT+1];
    tag_t               tail_c;

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [BITSIZE-1:0] rsp_data_q;
    logic               rsp_neg_q;

    // Search upward from the pointer for the first valid requester.
    always_comb begin
        gnt_any_c = 1'b0;
        gnt_id_c  = '0;
        idx_c     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_c = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (en && !gnt_any_c && bus.req_valid[idx_c]) begin
                gnt_any_c = 1'b1;
                gnt_id_c  = idx_c;
            end
        end
    end

    // Select the granted operand; its MSB marks a negative input.
    always_comb begin
        gnt_data_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt_id_c == ID_W'(k)) begin
                gnt_data_c = bus.req_data[k*BITSIZE +: BITSIZE];
            end
        end
    end

    assign gnt_neg_c     = gnt_data_c[BITSIZE-1];
    assign bus.req_ready = gnt_any_c ? (NUM_REQ'(1) << gnt_id_c) : '0;
    assign tail_c        = tag_q[PIPE_LAT];

    // Issue the accepted operand (negatives as zero) and advance the pointer past the winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            sq_data_in <= '0;
        end else begin
            sq_data_in <= (gnt_any_c && !gnt_neg_c) ? gnt_data_c : '0;
            if (gnt_any_c) begin
                ptr_q <= (gnt_id_c == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_c + ID_W'(1);
            end
        end
    end

    // Shadow tag pipeline; shifts every edge, no stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k <= PIPE_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= '{v: gnt_any_c, id: gnt_id_c, neg: gnt_any_c & gnt_neg_c};
            for (int unsigned k = 1; k <= PIPE_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Register the result onto the shared response bus; zero when nothing returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_neg_q   <= 1'b0;
        end else begin
            rsp_valid_q <= tail_c.v ? (NUM_REQ'(1) << tail_c.id) : '0;
            rsp_data_q  <= (tail_c.v && !tail_c.neg) ? sq_data_out : '0;
            rsp_neg_q   <= tail_c.v & tail_c.neg;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_neg   = rsp_neg_q;

    // Count operands accepted but not yet returned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({gnt_any_c, tail_c.v})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign idle = (inflight == '0) && (bus.req_valid == '0);

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Self-checking bench for sqrt_rr_scheduler with a delay-line sqrt model (out = in + 1).
module tb_sqrt_rr_scheduler;
    localparam int unsigned BITSIZE  = 16;
    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned ID_W     = 2;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned RSP_DLY  = PIPE_LAT + 2;

    logic               clk;
    logic               reset;
    logic               en;
    logic [BITSIZE-1:0] sq_data_in;
    logic [BITSIZE-1:0] sq_data_out;
    logic [CNT_W-1:0]   inflight;
    logic               idle;

    sqrt_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .BITSIZE(BITSIZE)) bus ();

    sqrt_rr_scheduler #(
        .BITSIZE(BITSIZE), .NUM_REQ(NUM_REQ), .PIPE_LAT(PIPE_LAT),
        .ID_W(ID_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .bus(bus),
        .sq_data_in(sq_data_in),
        .sq_data_out(sq_data_out),
        .inflight(inflight),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sqrt datapath stand-in: PIPE_LAT-edge delay line producing input + 1
    logic [BITSIZE-1:0] dl [PIPE_LAT];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE_LAT; k++) dl[k] <= '0;
        end else begin
            dl[0] <= sq_data_in + 16'd1;
            for (int k = 1; k < PIPE_LAT; k++) dl[k] <= dl[k-1];
        end
    end
    assign sq_data_out = dl[PIPE_LAT-1];

    typedef struct {
        logic [NUM_REQ-1:0] onehot;
        logic [BITSIZE-1:0] data;
        logic               neg;
        int unsigned        due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: pops the scoreboard on each strobe and tracks expected inflight.
    always @(negedge clk) begin
        exp_t e;
        int   exp_if;
        if (mon_en && !reset) begin
            if (bus.rsp_valid !== '0) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b data=%h at cyc %0d, expected no response",
                             bus.rsp_valid, bus.rsp_data, cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.rsp_valid !== e.onehot || bus.rsp_data !== e.data ||
                        bus.rsp_neg !== e.neg || cyc != e.due) begin
                        n_bad++;
                        $display("FAIL rsp: got valid=%b data=%h neg=%b cyc=%0d, expected valid=%b data=%h neg=%b cyc=%0d",
                                 bus.rsp_valid, bus.rsp_data, bus.rsp_neg, cyc,
                                 e.onehot, e.data, e.neg, e.due);
                    end
                end
            end else begin
                n_cmp++;
                if (bus.rsp_data !== '0 || bus.rsp_neg !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rsp_quiet: got data=%h neg=%b, expected 0000/0", bus.rsp_data, bus.rsp_neg);
                end
                if (sb.size() != 0 && sb[0].due <= cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_missing: got none at cyc %0d, expected valid=%b data=%h",
                             cyc, sb[0].onehot, sb[0].data);
                    void'(sb.pop_front());
                end
            end
            exp_if = 0;
            foreach (sb[i]) if (sb[i].due > cyc && sb[i].due <= cyc + PIPE_LAT + 1) exp_if++;
            n_cmp++;
            if (inflight !== CNT_W'(exp_if)) begin
                n_bad++;
                $display("FAIL inflight_track: got %0d, expected %0d at cyc %0d", inflight, exp_if, cyc);
            end
        end
    end

    task automatic set_data(input int i, input logic [BITSIZE-1:0] v);
        bus.req_data[i*BITSIZE +: BITSIZE] = v;
    endtask

    task automatic cycle_drive(input logic [NUM_REQ-1:0] v, input logic e, output logic [NUM_REQ-1:0] rdy);
        @(negedge clk);
        bus.req_valid = v;
        en = e;
        #1;
        rdy = bus.req_ready;
    endtask

    task automatic expect_rsp(input int id, input logic [BITSIZE-1:0] d, input logic neg);
        exp_t e;
        e.onehot = NUM_REQ'(1) << id;
        e.data   = d;
        e.neg    = neg;
        e.due    = cyc + RSP_DLY;
        sb.push_back(e);
    endtask

    task automatic drain();
        logic [NUM_REQ-1:0] rdy;
        for (int i = 0; i < 20 && sb.size() != 0; i++) cycle_drive('0, 1'b1, rdy);
        n_cmp++;
        if (sb.size() != 0 || inflight !== '0) begin
            n_bad++;
            $display("FAIL drain: got %0d outstanding inflight=%0d, expected 0/0", sb.size(), inflight);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; bus.req_valid = '0; bus.req_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== '0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp_data: got %h expected 0000", bus.rsp_data); end
        n_cmp++; if (bus.rsp_neg !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_neg: got %b expected 0", bus.rsp_neg); end
        n_cmp++; if (sq_data_in !== '0) begin n_bad++; $display("FAIL reset_sq_data_in: got %h expected 0000", sq_data_in); end
        n_cmp++; if (inflight !== '0) begin n_bad++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b expected 1", idle); end
        n_cmp++; if (bus.req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        mon_en = 1'b1;
    endtask

    task automatic test_rotation();
        logic [NUM_REQ-1:0] rdy;
        logic [NUM_REQ-1:0] exp_r;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 16'(16'h0100 * (i + 1)));
        for (int k = 0; k < 8; k++) begin
            cycle_drive(4'hF, 1'b1, rdy);
            exp_r = NUM_REQ'(1) << (k % 4);
            n_cmp++;
            if (rdy !== exp_r) begin n_bad++; $display("FAIL rotation_grant%0d: got %b expected %b", k, rdy, exp_r); end
            expect_rsp(k % 4, 16'(16'h0100 * (k % 4 + 1) + 1), 1'b0);
        end
        cycle_drive('0, 1'b1, rdy);
        n_cmp++;
        if (inflight !== 3'd5) begin n_bad++; $display("FAIL rotation_saturate: got %0d expected 5", inflight); end
        drain();
    endtask

    task automatic test_single();
        logic [NUM_REQ-1:0] rdy;
        set_data(2, 16'h2000);
        cycle_drive(4'b0100, 1'b1, rdy);
        n_cmp++;
        if (rdy !== 4'b0100) begin n_bad++; $display("FAIL single_grant: got %b expected 0100", rdy); end
        expect_rsp(2, 16'h2001, 1'b0);
        cycle_drive('0, 1'b1, rdy);
        n_cmp++;
        if (inflight !== 3'd1) begin n_bad++; $display("FAIL single_inflight: got %0d expected 1", inflight); end
        n_cmp++;
        if (sq_data_in !== 16'h2000) begin n_bad++; $display("FAIL single_issue: got %h expected 2000", sq_data_in); end
        drain();
    endtask

    task automatic test_wrap();
        logic [NUM_REQ-1:0] rdy;
        set_data(3, 16'h0333);
        set_data(0, 16'h0111);
        for (int k = 0; k < 4; k++) begin
            cycle_drive(4'b1001, 1'b1, rdy);
            n_cmp++;
            if (rdy !== ((k % 2 == 0) ? 4'b1000 : 4'b0001)) begin
                n_bad++; $display("FAIL wrap_grant%0d: got %b expected %b", k, rdy, (k % 2 == 0) ? 4'b1000 : 4'b0001);
            end
            if (k % 2 == 0) expect_rsp(3, 16'h0334, 1'b0);
            else            expect_rsp(0, 16'h0112, 1'b0);
        end
        drain();
    endtask

    task automatic test_negative();
        logic [NUM_REQ-1:0] rdy;
        set_data(1, 16'h8003);
        cycle_drive(4'b0010, 1'b1, rdy);
        n_cmp++;
        if (rdy !== 4'b0010) begin n_bad++; $display("FAIL neg_grant: got %b expected 0010", rdy); end
        expect_rsp(1, 16'h0000, 1'b1);
        cycle_drive('0, 1'b1, rdy);
        n_cmp++;
        if (sq_data_in !== 16'h0000) begin n_bad++; $display("FAIL neg_issue: got %h expected 0000", sq_data_in); end
        drain();
    endtask

    task automatic test_en_drop();
        logic [NUM_REQ-1:0] rdy;
        int ids[3] = '{2, 3, 0};
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 16'(16'h0100 * (i + 1)));
        for (int k = 0; k < 3; k++) begin
            cycle_drive(4'hF, 1'b1, rdy);
            n_cmp++;
            if (rdy !== NUM_REQ'(1) << ids[k]) begin n_bad++; $display("FAIL endrop_grant%0d: got %b expected %b", k, rdy, NUM_REQ'(1) << ids[k]); end
            expect_rsp(ids[k], 16'(16'h0100 * (ids[k] + 1) + 1), 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            cycle_drive(4'hF, 1'b0, rdy);
            n_cmp++;
            if (rdy !== '0 || idle !== 1'b0) begin
                n_bad++; $display("FAIL endrop_hold%0d: got ready=%b idle=%b expected 0000/0", k, rdy, idle);
            end
        end
        n_cmp++;
        if (sb.size() != 0 || inflight !== '0 || idle !== 1'b0) begin
            n_bad++; $display("FAIL endrop_final: got outstanding=%0d inflight=%0d idle=%b expected 0/0/0", sb.size(), inflight, idle);
        end
    endtask

    task automatic test_async_reset();
        logic [NUM_REQ-1:0] rdy;
        int stray;
        for (int k = 0; k < 3; k++) begin
            cycle_drive(4'hF, 1'b1, rdy);
            n_cmp++;
            if (rdy !== NUM_REQ'(1) << (k + 1)) begin n_bad++; $display("FAIL arst_grant%0d: got %b expected %b", k, rdy, NUM_REQ'(1) << (k + 1)); end
            expect_rsp(k + 1, 16'(16'h0100 * (k + 2) + 1), 1'b0);
        end
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        reset = 1'b1;
        bus.req_valid = '0;
        sb.delete();
        #1;
        n_cmp++;
        if (bus.rsp_valid !== '0 || bus.rsp_data !== '0 || bus.rsp_neg !== 1'b0 ||
            sq_data_in !== '0 || inflight !== '0) begin
            n_bad++;
            $display("FAIL arst_outputs: got valid=%b data=%h neg=%b sq_in=%h inflight=%0d expected all 0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_neg, sq_data_in, inflight);
        end
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            cycle_drive('0, 1'b1, rdy);
            if (bus.rsp_valid !== '0) stray++;
        end
        n_cmp++;
        if (stray != 0 || idle !== 1'b1) begin n_bad++; $display("FAIL arst_quiet: got %0d stray responses idle=%b expected 0/1", stray, idle); end
        cycle_drive(4'hF, 1'b1, rdy);
        n_cmp++;
        if (rdy !== 4'b0001) begin n_bad++; $display("FAIL arst_ptr_restart: got %b expected 0001", rdy); end
        expect_rsp(0, 16'h0101, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single();
        test_wrap();
        test_negative();
        test_en_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound, expected completion");
        $fatal(1, "timeout");
    end

endmodule
